// File: rtl/ahb_bram_slave_pkg.sv
// Shared AHB-Lite encodings for the BRAM responder.
// Ports: none (package). Provides HTRANS_*, HSIZE_* and HRESP_* constants.
// Latency: n/a. Backpressure: n/a.
package ahb_bram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_8  = 3'b000;
    localparam logic [2:0] HSIZE_16 = 3'b001;
    localparam logic [2:0] HSIZE_32 = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_bram_slave_if.sv
// AHB-Lite bus bundle between a master/decoder and the BRAM responder.
// Ports: hsel/haddr/hwrite/hsize/htrans/hwdata/hready towards the slave; hreadyout/hresp/hrdata back.
// Latency: n/a (wires only). Backpressure: carried by hready/hreadyout.
interface ahb_bram_slave_if;
    import ahb_bram_slave_pkg::*;

    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hsel, haddr, hwrite, hsize, htrans, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, hwrite, hsize, htrans, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_byteen_dec.sv
// Byte-lane decoder: maps HSIZE and the two low address bits to BRAM byte enables.
// Ports: hsize_i, addr_lo_i in; byteen_o (4 lanes), misalign_o out.
// Latency: combinational. Backpressure: none.
module ahb_byteen_dec
    import ahb_bram_slave_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] byteen_o,
    output logic       misalign_o
);

    always_comb begin
        byteen_o   = 4'b0000;
        misalign_o = 1'b0;
        case (hsize_i)
            HSIZE_8:  byteen_o = 4'b0001 << addr_lo_i;
            HSIZE_16: begin
                // Bit 0 is ignored for lane selection, so a misaligned
                // halfword lands on its aligned lanes when errors are off.
                byteen_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_lo_i[0];
            end
            HSIZE_32: begin
                byteen_o   = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: byteen_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_bram_slave.sv
// AHB-Lite responder mapping a synchronous block RAM onto the system bus.
// Latency: writes 1 data-phase cycle (zero wait), reads 2 (one wait state), errors 2.
// Backpressure: hreadyout low in RD_WAIT/ERR1; no accept while bus hready_i is low.
// Ports: clk, resetn (async active-low), bus (AHB slave modport), bram_* towards the RAM.
// Build option: define AHB_BRAM_SLV_ERR_EN for ERROR responses on oversize,
// misaligned or out-of-window transfers; without it addresses are aligned/wrapped.
module ahb_bram_slave
    import ahb_bram_slave_pkg::*;
#(
    parameter int AWID     = 10,
    parameter int WIN_BITS = 18
) (
    input  logic                clk,
    input  logic                resetn,
    ahb_bram_slave_if.slave     bus,
    output logic [AWID-1:0]     bram_addr_o,
    output logic                bram_wren_o,
    output logic [3:0]          bram_byteen_o,
    output logic [31:0]         bram_wrdata_o,
    input  logic [31:0]         bram_rddata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_RD_WAIT,
        S_RD_DATA
`ifdef AHB_BRAM_SLV_ERR_EN
        ,
        S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t          state_q, state_d, accept_tgt;
    logic [AWID-1:0] addr_q;
    logic [3:0]      byteen_q;
    logic [3:0]      byteen;
    logic            misalign;
    logic            rdy;
    logic            accept;

    ahb_byteen_dec u_byteen_dec (
        .hsize_i    (bus.hsize),
        .addr_lo_i  (bus.haddr[1:0]),
        .byteen_o   (byteen),
        .misalign_o (misalign)
    );

    // Only stalling states drop ready; everything else may take a pipelined
    // address phase in the same cycle as its own data phase.
    always_comb begin
        rdy = 1'b1;
        if (state_q == S_RD_WAIT) rdy = 1'b0;
`ifdef AHB_BRAM_SLV_ERR_EN
        if (state_q == S_ERR1) rdy = 1'b0;
`endif
    end

    assign accept = bus.hsel & bus.hready & bus.htrans[1] & rdy;

`ifdef AHB_BRAM_SLV_ERR_EN
    logic xfer_err;
    assign xfer_err = (bus.hsize > HSIZE_32) | misalign
                    | (|bus.haddr[WIN_BITS-1:AWID+2]);
    assign accept_tgt = xfer_err    ? S_ERR1
                      : bus.hwrite ? S_WR_DATA : S_RD_WAIT;

    logic unused_ok;
    assign unused_ok = ^{bus.haddr[31:WIN_BITS], bus.htrans[0]};
`else
    // Word index drops haddr[1:0] (forced alignment) and keeps only AWID
    // bits, so out-of-window addresses wrap around the RAM.
    assign accept_tgt = bus.hwrite ? S_WR_DATA : S_RD_WAIT;

    logic unused_ok;
    assign unused_ok = ^{bus.haddr[31:AWID+2], bus.htrans[0], misalign};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            byteen_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= bus.haddr[AWID+1:2];
                byteen_q <= byteen;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.hreadyout = rdy;
        bus.hresp     = HRESP_OKAY;
        bus.hrdata    = '0;
        bram_addr_o   = addr_q;
        bram_wren_o   = 1'b0;
        bram_byteen_o = 4'b0000;
        bram_wrdata_o = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = accept_tgt;
            end
            S_WR_DATA: begin
                bram_wren_o   = 1'b1;
                bram_byteen_o = byteen_q;
                bram_wrdata_o = bus.hwdata;
                if (accept)          state_d = accept_tgt;
                else if (bus.hready) state_d = S_IDLE;
            end
            S_RD_WAIT: begin
                state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                bus.hrdata = bram_rddata_i;
                if (accept)          state_d = accept_tgt;
                else if (bus.hready) state_d = S_IDLE;
            end
`ifdef AHB_BRAM_SLV_ERR_EN
            S_ERR1: begin
                bus.hresp = HRESP_ERROR;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                bus.hresp = HRESP_ERROR;
                if (accept)          state_d = accept_tgt;
                else if (bus.hready) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_bram_slave.sv
// Directed bench for ahb_bram_slave with a behavioural synchronous BRAM.
// Ports: none (top-level bench).
// Latency/backpressure: bench drives hready from the slave, optionally stalled.
module tb_ahb_bram_slave;
    import ahb_bram_slave_pkg::*;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic [9:0]  bram_addr;
    logic        bram_wren;
    logic [3:0]  bram_byteen;
    logic [31:0] bram_wrdata;
    logic [31:0] bram_rddata;
    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    ahb_bram_slave_if bus ();
    assign bus.hready = bus.hreadyout & ~stall;

    ahb_bram_slave #(.AWID(10), .WIN_BITS(18)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .bus           (bus),
        .bram_addr_o   (bram_addr),
        .bram_wren_o   (bram_wren),
        .bram_byteen_o (bram_byteen),
        .bram_wrdata_o (bram_wrdata),
        .bram_rddata_i (bram_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_wren) begin
            for (int b = 0; b < 4; b++)
                if (bram_byteen[b]) mem[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
        end
        bram_rddata <= mem[bram_addr];
    end

    task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
        bus.hsel = 1'b1; bus.haddr = a; bus.hwrite = wr; bus.hsize = sz; bus.htrans = HTRANS_NONSEQ;
    endtask

    task automatic idle_phase();
        bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                            output logic o_wren, output logic [3:0] o_be, output logic [9:0] o_addr,
                            output logic o_rdy, output logic o_resp);
        @(posedge clk); #1; addr_phase(a, 1'b1, sz);
        @(posedge clk); #1; idle_phase(); bus.hwdata = d;
        @(negedge clk);
        o_wren = bram_wren; o_be = bram_byteen; o_addr = bram_addr; o_rdy = bus.hreadyout; o_resp = bus.hresp;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] sz,
                           output logic w_rdy, output logic w_resp, output logic [9:0] w_addr, output logic w_wren,
                           output logic d_rdy, output logic d_resp, output logic [31:0] d_data, output logic d_wren);
        @(posedge clk); #1; addr_phase(a, 1'b0, sz);
        @(posedge clk); #1; idle_phase();
        @(negedge clk);
        w_rdy = bus.hreadyout; w_resp = bus.hresp; w_addr = bram_addr; w_wren = bram_wren;
        @(negedge clk);
        d_rdy = bus.hreadyout; d_resp = bus.hresp; d_data = bus.hrdata; d_wren = bram_wren;
    endtask

    logic        o_wren, o_rdy, o_resp, w_rdy, w_resp, w_wren, d_rdy, d_resp, d_wren;
    logic [3:0]  o_be;
    logic [9:0]  o_addr, w_addr;
    logic [31:0] d_data;

    task automatic test_reset();
        #3;
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) begin failures++; $display("FAIL reset_rdy_resp got %b expected 10", {bus.hreadyout, bus.hresp}); end
        checks++; if (bus.hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata got %h expected 0", bus.hrdata); end
        checks++; if ({bram_wren, bram_byteen, bram_addr} !== 15'h0) begin failures++; $display("FAIL reset_bram_ctl got %h expected 0", {bram_wren, bram_byteen, bram_addr}); end
        checks++; if (bram_wrdata !== 32'h0) begin failures++; $display("FAIL reset_wrdata got %h expected 0", bram_wrdata); end
        @(posedge clk); #1; resetn = 1'b1;
    endtask

    task automatic test_word_rw();
        do_write(32'h0004_0010, HSIZE_32, 32'hDEAD_BEEF, o_wren, o_be, o_addr, o_rdy, o_resp);
        checks++; if ({o_wren, o_be, o_rdy, o_resp} !== 7'b1_1111_10) begin failures++; $display("FAIL wr32_ctl got %b expected 1111110", {o_wren, o_be, o_rdy, o_resp}); end
        checks++; if (o_addr !== 10'h004) begin failures++; $display("FAIL wr32_addr got %h expected 004", o_addr); end
        checks++; if (bram_wrdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr32_data got %h expected deadbeef", bram_wrdata); end
        do_read(32'h0004_0010, HSIZE_32, w_rdy, w_resp, w_addr, w_wren, d_rdy, d_resp, d_data, d_wren);
        checks++; if ({w_rdy, w_resp, w_wren} !== 3'b000) begin failures++; $display("FAIL rd32_wait got %b expected 000", {w_rdy, w_resp, w_wren}); end
        checks++; if (w_addr !== 10'h004) begin failures++; $display("FAIL rd32_addr got %h expected 004", w_addr); end
        checks++; if ({d_rdy, d_resp} !== 2'b10) begin failures++; $display("FAIL rd32_done got %b expected 10", {d_rdy, d_resp}); end
        checks++; if (d_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd32_data got %h expected deadbeef", d_data); end
        @(negedge clk);
        checks++; if (bus.hrdata !== 32'h0) begin failures++; $display("FAIL rd32_idle_hrdata got %h expected 0", bus.hrdata); end
    endtask

    task automatic test_byte_half();
        do_write(32'h0004_0013, HSIZE_8, 32'hAB00_0000, o_wren, o_be, o_addr, o_rdy, o_resp);
        checks++; if ({o_wren, o_be} !== 5'b1_1000) begin failures++; $display("FAIL wr8_be got %b expected 11000", {o_wren, o_be}); end
        do_write(32'h0004_0010, HSIZE_16, 32'h0000_1234, o_wren, o_be, o_addr, o_rdy, o_resp);
        checks++; if ({o_wren, o_be} !== 5'b1_0011) begin failures++; $display("FAIL wr16_be got %b expected 10011", {o_wren, o_be}); end
        do_write(32'h0004_0022, HSIZE_16, 32'h5555_0000, o_wren, o_be, o_addr, o_rdy, o_resp);
        checks++; if ({o_be, o_addr} !== {4'b1100, 10'h008}) begin failures++; $display("FAIL wr16_hi got %h expected %h", {o_be, o_addr}, {4'b1100, 10'h008}); end
        do_read(32'h0004_0010, HSIZE_32, w_rdy, w_resp, w_addr, w_wren, d_rdy, d_resp, d_data, d_wren);
        checks++; if (d_data !== 32'hABAD_1234) begin failures++; $display("FAIL merge_data got %h expected abad1234", d_data); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1; addr_phase(32'h0004_0020, 1'b1, HSIZE_32);
        @(posedge clk); #1; bus.hwdata = 32'h5A5A_C3C3; addr_phase(32'h0004_0020, 1'b0, HSIZE_32);
        @(negedge clk);
        checks++; if ({bram_wren, bram_addr, bus.hreadyout} !== {1'b1, 10'h008, 1'b1}) begin failures++; $display("FAIL b2b_wr got %h expected %h", {bram_wren, bram_addr, bus.hreadyout}, {1'b1, 10'h008, 1'b1}); end
        @(posedge clk); #1; idle_phase();
        @(negedge clk);
        checks++; if ({bram_wren, bus.hreadyout, bram_addr} !== {1'b0, 1'b0, 10'h008}) begin failures++; $display("FAIL b2b_wait got %h expected %h", {bram_wren, bus.hreadyout, bram_addr}, {1'b0, 1'b0, 10'h008}); end
        @(negedge clk);
        checks++; if ({bus.hreadyout, bus.hrdata} !== {1'b1, 32'h5A5A_C3C3}) begin failures++; $display("FAIL b2b_rd got %h expected 15a5ac3c3", {bus.hreadyout, bus.hrdata}); end
    endtask

    task automatic test_err_or_align();
`ifdef AHB_BRAM_SLV_ERR_EN
        do_read(32'h0004_0002, HSIZE_32, w_rdy, w_resp, w_addr, w_wren, d_rdy, d_resp, d_data, d_wren);
        checks++; if ({w_rdy, w_resp, w_wren} !== 3'b010) begin failures++; $display("FAIL err1_misalign got %b expected 010", {w_rdy, w_resp, w_wren}); end
        checks++; if ({d_rdy, d_resp, d_wren, d_data} !== {3'b110, 32'h0}) begin failures++; $display("FAIL err2_misalign got %h expected %h", {d_rdy, d_resp, d_wren, d_data}, {3'b110, 32'h0}); end
        do_write(32'h0004_1010, HSIZE_32, 32'hFFFF_FFFF, o_wren, o_be, o_addr, o_rdy, o_resp);
        checks++; if ({o_wren, o_rdy, o_resp} !== 3'b001) begin failures++; $display("FAIL err1_range got %b expected 001", {o_wren, o_rdy, o_resp}); end
        @(negedge clk);
        checks++; if ({bram_wren, bus.hreadyout, bus.hresp} !== 3'b011) begin failures++; $display("FAIL err2_range got %b expected 011", {bram_wren, bus.hreadyout, bus.hresp}); end
`else
        do_read(32'h0004_0012, HSIZE_32, w_rdy, w_resp, w_addr, w_wren, d_rdy, d_resp, d_data, d_wren);
        checks++; if ({w_rdy, w_resp, w_addr} !== {2'b00, 10'h004}) begin failures++; $display("FAIL align_wait got %h expected %h", {w_rdy, w_resp, w_addr}, {2'b00, 10'h004}); end
        checks++; if ({d_rdy, d_resp, d_data} !== {2'b10, 32'hABAD_1234}) begin failures++; $display("FAIL align_data got %h expected %h", {d_rdy, d_resp, d_data}, {2'b10, 32'hABAD_1234}); end
        do_read(32'h0004_1010, HSIZE_32, w_rdy, w_resp, w_addr, w_wren, d_rdy, d_resp, d_data, d_wren);
        checks++; if (w_addr !== 10'h004) begin failures++; $display("FAIL wrap_addr got %h expected 004", w_addr); end
        checks++; if ({d_resp, d_data} !== {1'b0, 32'hABAD_1234}) begin failures++; $display("FAIL wrap_data got %h expected %h", {d_resp, d_data}, {1'b0, 32'hABAD_1234}); end
`endif
    endtask

    task automatic test_stall();
        @(posedge clk); #1; stall = 1'b1; addr_phase(32'h0004_0030, 1'b1, HSIZE_32); bus.hwdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({bram_wren, bus.hreadyout, bus.hresp} !== 3'b010) begin failures++; $display("FAIL stall_hold%0d got %b expected 010", i, {bram_wren, bus.hreadyout, bus.hresp}); end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(posedge clk); #1; idle_phase(); bus.hwdata = 32'h1122_3344;
        @(negedge clk);
        checks++; if ({bram_wren, bram_addr} !== {1'b1, 10'h00C}) begin failures++; $display("FAIL stall_accept got %h expected %h", {bram_wren, bram_addr}, {1'b1, 10'h00C}); end
        do_read(32'h0004_0030, HSIZE_32, w_rdy, w_resp, w_addr, w_wren, d_rdy, d_resp, d_data, d_wren);
        checks++; if (d_data !== 32'h1122_3344) begin failures++; $display("FAIL stall_rdback got %h expected 11223344", d_data); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1; addr_phase(32'h0004_0010, 1'b0, HSIZE_32);
        @(posedge clk); #1; idle_phase();
        @(negedge clk); #1; resetn = 1'b0; #1;
        checks++; if ({bus.hreadyout, bus.hresp, bus.hrdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL rst_rdwait got %h expected %h", {bus.hreadyout, bus.hresp, bus.hrdata}, {2'b10, 32'h0}); end
        @(posedge clk); #1; resetn = 1'b1;
        do_read(32'h0004_0010, HSIZE_32, w_rdy, w_resp, w_addr, w_wren, d_rdy, d_resp, d_data, d_wren);
        checks++; if ({w_rdy, d_rdy, d_data} !== {2'b01, 32'hABAD_1234}) begin failures++; $display("FAIL rst_after_rd got %h expected %h", {w_rdy, d_rdy, d_data}, {2'b01, 32'hABAD_1234}); end
        @(posedge clk); #1; addr_phase(32'h0004_0010, 1'b1, HSIZE_32);
        @(posedge clk); #1; idle_phase(); bus.hwdata = 32'hFFFF_FFFF;
        #2; resetn = 1'b0; #1;
        checks++; if (bram_wren !== 1'b0) begin failures++; $display("FAIL rst_wr_wren got %b expected 0", bram_wren); end
        @(posedge clk); #1; resetn = 1'b1;
        do_read(32'h0004_0010, HSIZE_32, w_rdy, w_resp, w_addr, w_wren, d_rdy, d_resp, d_data, d_wren);
        checks++; if (d_data !== 32'hABAD_1234) begin failures++; $display("FAIL rst_wr_dropped got %h expected abad1234", d_data); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; stall = 1'b0;
        bus.hsel = 1'b0; bus.haddr = '0; bus.hwrite = 1'b0; bus.hsize = HSIZE_32;
        bus.htrans = HTRANS_IDLE; bus.hwdata = '0;
        test_reset();
        test_word_rw();
        test_byte_half();
        test_back_to_back();
        test_err_or_align();
        test_stall();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
